// File: rtl/hmmm_bus_ctrl.sv
// Host-side bus controller for the hmmm core: program load, run control, input FIFO, output reg.
// Optional watchdog enabled by defining HMMM_WATCHDOG_EN.
module hmmm_bus_ctrl #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned IN_DEPTH   = 4,
   parameter int unsigned WDT_CYCLES = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic              err_underflow,
   output logic              err_overflow,
   output logic              err_timeout,
   output logic              core_rst,
   output logic              core_pgrm_addr,
   output logic              core_pgrm_data,
   input  logic              core_read,
   input  logic              core_write,
   input  logic              core_halt,
   input  logic [DATA_W-1:0] core_bus_in,
   output logic [DATA_W-1:0] core_bus_out,
   output logic              core_bus_oe
);

   localparam int unsigned PTR_W = $clog2(IN_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      StIdle,
      StLdAddr,
      StLdData,
      StRun,
      StHalted
   } state_e;

   state_e state_q, state_d;

   logic [ADDR_W-1:0] ld_addr_q;
   logic [DATA_W-1:0] ld_data_q;

   logic [DATA_W-1:0] fifo_mem [IN_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              fifo_empty, fifo_full;

   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic              err_underflow_q, err_overflow_q;

   logic accept_load, accept_start, flush, run_active;
   logic rd_svc, wr_svc, push, pop;
   logic wdt_expire;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(IN_DEPTH));

   assign accept_load  = (state_q == StIdle) & ld_valid;
   assign accept_start = (state_q == StIdle) & ~ld_valid & start;
   // Abort is ignored in IDLE: nothing is running and the FIFO may be pre-filled.
   assign flush        = abort & (state_q != StIdle);
   assign run_active   = (state_q == StRun) & ~abort;
   assign rd_svc       = run_active & core_read;
   assign wr_svc       = run_active & core_write & ~core_read;

   assign push = in_valid & ~fifo_full & ~flush;
   assign pop  = rd_svc & ~fifo_empty;

   assign ld_ready       = (state_q == StIdle);
   assign in_ready       = ~fifo_full;
   assign busy           = (state_q == StLdAddr) | (state_q == StLdData) | (state_q == StRun);
   assign done           = (state_q == StHalted);
   assign core_rst       = (state_q == StIdle);
   assign core_pgrm_addr = (state_q == StLdAddr);
   assign core_pgrm_data = (state_q == StLdData);
   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign err_underflow  = err_underflow_q;
   assign err_overflow   = err_overflow_q;

`ifdef HMMM_WATCHDOG_EN
   localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

   logic [WDT_W-1:0] wdt_q;
   logic             err_timeout_q;

   assign wdt_expire  = (state_q == StRun) & (wdt_q == WDT_W'(WDT_CYCLES - 1));
   assign err_timeout = err_timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_q         <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         if (accept_start) begin
            wdt_q         <= '0;
            err_timeout_q <= 1'b0;
         end else if (run_active) begin
            wdt_q <= wdt_q + 1'b1;
            if (wdt_expire && !core_halt) begin
               err_timeout_q <= 1'b1;
            end
         end
      end
   end
`else
   logic unused_wdt;

   assign unused_wdt  = ^WDT_CYCLES;
   assign wdt_expire  = 1'b0;
   assign err_timeout = 1'b0;
`endif

   // Bus is driven from latched load words, or from the FIFO head while the core reads.
   always_comb begin
      core_bus_oe  = 1'b0;
      core_bus_out = '0;
      unique case (state_q)
         StLdAddr: begin
            core_bus_oe  = 1'b1;
            core_bus_out = DATA_W'(ld_addr_q);
         end
         StLdData: begin
            core_bus_oe  = 1'b1;
            core_bus_out = ld_data_q;
         end
         StRun: begin
            if (core_read) begin
               core_bus_oe  = 1'b1;
               core_bus_out = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ld_valid) begin
                  state_d = StLdAddr;
               end else if (start) begin
                  state_d = StRun;
               end
            end
            StLdAddr: state_d = StLdData;
            StLdData: state_d = StIdle;
            StRun: begin
               if (core_halt || wdt_expire) begin
                  state_d = StHalted;
               end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         ld_addr_q <= '0;
         ld_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept_load) begin
            ld_addr_q <= ld_addr;
            ld_data_q <= ld_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q     <= 1'b0;
         out_data_q      <= '0;
         err_underflow_q <= 1'b0;
         err_overflow_q  <= 1'b0;
      end else begin
         if (flush) begin
            out_valid_q <= 1'b0;
         end else if (wr_svc) begin
            out_valid_q <= 1'b1;
            out_data_q  <= core_bus_in;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end

         // Sticky errors: cleared only by reset or an accepted start.
         if (accept_start) begin
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
         end else begin
            if (rd_svc && fifo_empty) begin
               err_underflow_q <= 1'b1;
            end
            if (wr_svc && out_valid_q && !out_ready) begin
               err_overflow_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hmmm_bus_ctrl.sv
// Directed bench for hmmm_bus_ctrl with FIFO and load-strobe scoreboards.
// Watchdog section is compiled when HMMM_WATCHDOG_EN is defined.
module tb_hmmm_bus_ctrl;

   localparam int unsigned ADDR_W   = 8;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned IN_DEPTH = 4;
`ifdef HMMM_WATCHDOG_EN
   localparam int unsigned WDT_CYCLES = 16;
`else
   localparam int unsigned WDT_CYCLES = 65535;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              ld_valid, ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              start, abort;
   logic              in_valid, in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid, out_ready;
   logic [DATA_W-1:0] out_data;
   logic              busy, done;
   logic              err_underflow, err_overflow, err_timeout;
   logic              core_rst, core_pgrm_addr, core_pgrm_data;
   logic              core_read, core_write, core_halt;
   logic [DATA_W-1:0] core_bus_in, core_bus_out;
   logic              core_bus_oe;

   int n_vec = 0;
   int n_err = 0;

   logic [DATA_W-1:0] fifo_q [$];
   logic [DATA_W-1:0] ld_q [$];

   hmmm_bus_ctrl #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .IN_DEPTH  (IN_DEPTH),
      .WDT_CYCLES(WDT_CYCLES)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ld_valid      (ld_valid),
      .ld_ready      (ld_ready),
      .ld_addr       (ld_addr),
      .ld_data       (ld_data),
      .start         (start),
      .abort         (abort),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .busy          (busy),
      .done          (done),
      .err_underflow (err_underflow),
      .err_overflow  (err_overflow),
      .err_timeout   (err_timeout),
      .core_rst      (core_rst),
      .core_pgrm_addr(core_pgrm_addr),
      .core_pgrm_data(core_pgrm_data),
      .core_read     (core_read),
      .core_write    (core_write),
      .core_halt     (core_halt),
      .core_bus_in   (core_bus_in),
      .core_bus_out  (core_bus_out),
      .core_bus_oe   (core_bus_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Host push: expectation taken from the bench's own occupancy model.
   task automatic host_push(input logic [DATA_W-1:0] w);
      in_valid = 1'b1;
      in_data  = w;
      #1;
      check("in_ready", {31'b0, in_ready}, {31'b0, (fifo_q.size() < IN_DEPTH)});
      if (fifo_q.size() < IN_DEPTH) fifo_q.push_back(w);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic core_rd();
      logic [DATA_W-1:0] exp;
      logic              was_empty;
      core_read = 1'b1;
      #1;
      was_empty = (fifo_q.size() == 0);
      exp = was_empty ? '0 : fifo_q.pop_front();
      check("rd_oe", {31'b0, core_bus_oe}, 32'd1);
      check("rd_bus", {16'b0, core_bus_out}, {16'b0, exp});
      tick();
      core_read = 1'b0;
      if (was_empty) check("underflow", {31'b0, err_underflow}, 32'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   initial begin
      logic [ADDR_W-1:0] addrs [3];
      logic [DATA_W-1:0] words [3];
      logic [DATA_W-1:0] exp;
      int                cyc;
      addrs[0] = 8'd0; addrs[1] = 8'd1; addrs[2] = 8'd2;
      words[0] = 16'h112A; words[1] = 16'h0102; words[2] = 16'h0000;

      rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0; abort = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0; core_read = 1'b0; core_write = 1'b0;
      core_halt = 1'b0; core_bus_in = '0;
      tick();
      tick();

      // Reset state
      check("rst_core_rst", {31'b0, core_rst}, 32'd1);
      check("rst_oe", {31'b0, core_bus_oe}, 32'd0);
      check("rst_bus", {16'b0, core_bus_out}, 32'd0);
      check("rst_flags", {24'b0, out_valid, busy, done, err_underflow, err_overflow,
                          err_timeout, core_pgrm_addr, core_pgrm_data}, 32'd0);
      check("rst_ready", {30'b0, ld_ready, in_ready}, 32'd3);
      rst = 1'b0;
      tick();

      // Program load: addr/data strobe pair per word
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1;
         ld_addr  = addrs[i];
         ld_data  = words[i];
         #1;
         check("ld_ready_idle", {31'b0, ld_ready}, 32'd1);
         ld_q.push_back({{(DATA_W - ADDR_W){1'b0}}, addrs[i]});
         ld_q.push_back(words[i]);
         tick();
         ld_valid = 1'b0;
         check("ld_addr_strb", {29'b0, core_pgrm_addr, core_pgrm_data, core_rst}, 32'd4);
         check("ld_ready_busy", {30'b0, ld_ready, core_bus_oe}, 32'd1);
         exp = (ld_q.size() != 0) ? ld_q.pop_front() : 16'hDEAD;
         check("ld_addr_bus", {16'b0, core_bus_out}, {16'b0, exp});
         tick();
         check("ld_data_strb", {29'b0, core_pgrm_addr, core_pgrm_data, core_rst}, 32'd2);
         check("ld_ready_busy2", {30'b0, ld_ready, core_bus_oe}, 32'd1);
         exp = (ld_q.size() != 0) ? ld_q.pop_front() : 16'hDEAD;
         check("ld_data_bus", {16'b0, core_bus_out}, {16'b0, exp});
         tick();
         check("ld_back_idle", {30'b0, core_rst, ld_ready}, 32'd3);
      end

      // Run, one core write, halt
      pulse_start();
      check("run_state", {29'b0, busy, core_rst, done}, 32'd4);
      core_write  = 1'b1;
      core_bus_in = 16'h002A;
      tick();
      core_write = 1'b0;
      check("wr_valid", {31'b0, out_valid}, 32'd1);
      check("wr_data", {16'b0, out_data}, 32'h002A);
      core_halt = 1'b1;
      tick();
      core_halt = 1'b0;
      check("halted", {29'b0, done, busy, core_rst}, 32'd4);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("out_consumed", {31'b0, out_valid}, 32'd0);
      pulse_abort();
      check("abort_idle", {30'b0, core_rst, done}, 32'd2);

      // FIFO reads including underflow
      host_push(16'h0005);
      host_push(16'h0007);
      pulse_start();
      core_rd();
      core_rd();
      core_rd();

      // Fill to depth, overfill, then simultaneous push and pop on a full FIFO
      for (int i = 0; i < 5; i++) host_push(16'h0011 + 16'(i));
      check("full_in_ready", {31'b0, in_ready}, 32'd0);
      in_valid  = 1'b1;
      in_data   = 16'h0099;
      core_read = 1'b1;
      #1;
      exp = fifo_q.pop_front();
      check("full_pp_bus", {16'b0, core_bus_out}, {16'b0, exp});
      tick();
      in_valid  = 1'b0;
      core_read = 1'b0;
      check("after_pp_ready", {31'b0, in_ready}, 32'd1);
      while (fifo_q.size() != 0) core_rd();

      // Output overflow, and read+write collision
      core_write  = 1'b1;
      core_bus_in = 16'hAAAA;
      tick();
      core_bus_in = 16'hBBBB;
      tick();
      core_write = 1'b0;
      check("ovf_flag", {31'b0, err_overflow}, 32'd1);
      check("ovf_data", {16'b0, out_data}, 32'hBBBB);
      core_read   = 1'b1;
      core_write  = 1'b1;
      core_bus_in = 16'hCCCC;
      tick();
      core_read  = 1'b0;
      core_write = 1'b0;
      check("rw_collide", {16'b0, out_data}, 32'hBBBB);

      // Abort flushes FIFO and output, errors stay
      host_push(16'h0123);
      pulse_abort();
      fifo_q.delete();
      check("abort2_state", {29'b0, core_rst, busy, out_valid}, 32'd4);
      check("abort2_errs", {30'b0, err_overflow, err_underflow}, 32'd3);
      pulse_start();
      check("start_clr_errs", {30'b0, err_overflow, err_underflow}, 32'd0);
      core_rd();
      pulse_abort();

      // Load beats start in the same cycle
      ld_valid = 1'b1;
      start    = 1'b1;
      ld_addr  = 8'h7F;
      ld_data  = 16'h5A5A;
      tick();
      ld_valid = 1'b0;
      start    = 1'b0;
      check("ld_wins", {31'b0, core_pgrm_addr}, 32'd1);
      check("ld_wins_bus", {16'b0, core_bus_out}, 32'h007F);
      tick();
      tick();
      check("start_dropped", {30'b0, busy, core_rst}, 32'd1);

      // Reset mid-run
      pulse_start();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_midrun", {30'b0, busy, core_rst}, 32'd1);

      // Watchdog
      pulse_start();
      cyc = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (done && cyc == 0) cyc = i;
      end
`ifdef HMMM_WATCHDOG_EN
      check("wdt_cycles", cyc, WDT_CYCLES);
      check("wdt_flag", {31'b0, err_timeout}, 32'd1);
`else
      check("no_wdt_halt", cyc, 32'd0);
      check("no_wdt_flag", {31'b0, err_timeout}, 32'd0);
`endif
      pulse_abort();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "bench timeout");
   end

endmodule
